// File: rtl/vga_fb_scheduler.sv
`timescale 1ns/1ps
// Purpose : 640x480@60 VGA timing plus owner of the single framebuffer RAM port,
//           interleaving display fetches with round-robin game-logic writes.
// Latency : display outputs lag the pixel counters by one pixel (2 clk); grants are
//           combinational, in the same cycle as the request.
// Backpressure: writers hold wr_req until wr_gnt; display slots are never stalled.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   wr_req/wr_addrN/
//   wr_dataN/wr_gnt       two writer request channels, one-hot grant
//   mem_addr/mem_we/
//   mem_wdata/mem_rdata   framebuffer RAM port (1-cycle synchronous read)
//   o_hsync/o_vsync/o_de/
//   o_pix                 registered display outputs
//   o_frame_start/o_vblank frame status

module vga_fb_scheduler #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_ACTIVE = 640,
    parameter int   H_TOTAL  = 800,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_ACTIVE = 480,
    parameter int   V_TOTAL  = 525,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wr_req,
    input  logic [14:0] wr_addr0,
    input  logic [14:0] wr_addr1,
    input  logic [7:0]  wr_data0,
    input  logic [7:0]  wr_data1,
    output logic [1:0]  wr_gnt,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [7:0]  o_pix,
    output logic        o_frame_start,
    output logic        o_vblank
);

    localparam logic [9:0]  HS_END  = 10'(H_SYNC);
    localparam logic [9:0]  H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_STOP  = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VS_END  = 10'(V_SYNC);
    localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_STOP  = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    // 160x120 framebuffer; anything at or above this is outside the RAM.
    localparam logic [14:0] FB_SIZE = 15'd19200;

    typedef enum logic {
        S_WR   = 1'b0,
        S_DISP = 1'b1
    } slot_t;

    logic        r_phase;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_v_cnt;
    logic        r_rr_last;
    slot_t       r_slot;
    logic [7:0]  r_pix;
    logic        r_de;
    logic        r_hsync;
    logic        r_vsync;

    logic        w_phase_nxt;
    logic [9:0]  w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic        w_active;
    logic        w_active_nxt;
    slot_t       w_slot_nxt;
    logic [9:0]  w_hq;
    logic [9:0]  w_vq;
    logic [14:0] w_disp_addr;
    logic        w_any;
    logic        w_sel;
    logic [14:0] w_sel_addr;
    logic [7:0]  w_sel_data;

    function automatic logic in_active(input logic [9:0] h, input logic [9:0] v);
        return (h >= H_START) && (h < H_STOP) && (v >= V_START) && (v < V_STOP);
    endfunction

    // Counter advance: one pixel spans two clocks, counters move on the phase=1 edge.
    always_comb begin
        w_phase_nxt = ~r_phase;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        if (r_phase) begin
            if (r_h_cnt == H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
            end else begin
                w_h_nxt = r_h_cnt + 10'd1;
            end
        end
    end

    assign w_active     = in_active(r_h_cnt, r_v_cnt);
    assign w_active_nxt = in_active(w_h_nxt, w_v_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
        end
    end

    // Slot FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= S_WR;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    // Slot FSM: next state. The slot for the coming cycle is decided from the
    // coming counter values so that r_slot lines up with r_h_cnt/r_v_cnt.
    always_comb begin
        w_slot_nxt = S_WR;
        if (!w_phase_nxt && w_active_nxt) begin
            w_slot_nxt = S_DISP;
        end
    end

    // Framebuffer address: each framebuffer pixel covers a 4x4 block of screen pixels.
    // row*160 is built as row*128 + row*32.
    assign w_hq        = (r_h_cnt - H_START) >> 2;
    assign w_vq        = (r_v_cnt - V_START) >> 2;
    assign w_disp_addr = 15'(({5'b0, w_vq} << 7) + ({5'b0, w_vq} << 5) + {5'b0, w_hq});

    // Round-robin pick: with both requesting, the writer not served last wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = 1'b0;
        if (!rst && (r_slot == S_WR)) begin
            case (wr_req)
                2'b01: begin
                    w_any = 1'b1;
                    w_sel = 1'b0;
                end
                2'b10: begin
                    w_any = 1'b1;
                    w_sel = 1'b1;
                end
                2'b11: begin
                    w_any = 1'b1;
                    w_sel = ~r_rr_last;
                end
                default: begin
                    w_any = 1'b0;
                    w_sel = 1'b0;
                end
            endcase
        end
    end

    assign w_sel_addr = w_sel ? wr_addr1 : wr_addr0;
    assign w_sel_data = w_sel ? wr_data1 : wr_data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (w_any) begin
            r_rr_last <= w_sel;
        end
    end

    // Slot FSM: outputs. Out-of-range writes are still granted so the writer
    // moves on, but the RAM write strobe is suppressed.
    always_comb begin
        wr_gnt    = 2'b00;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (!rst) begin
            case (r_slot)
                S_DISP: begin
                    mem_addr = w_disp_addr;
                end
                default: begin
                    if (w_any) begin
                        wr_gnt    = w_sel ? 2'b10 : 2'b01;
                        mem_addr  = w_sel_addr;
                        mem_wdata = w_sel_data;
                        mem_we    = (w_sel_addr < FB_SIZE);
                    end
                end
            endcase
        end
    end

    // Display stage: the RAM word fetched on phase=0 arrives on phase=1, so all
    // display outputs are captured together on the phase=1 edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix   <= '0;
            r_de    <= 1'b0;
            r_hsync <= SYNC_POL;
            r_vsync <= SYNC_POL;
        end else if (r_phase) begin
            r_de    <= w_active;
            r_pix   <= w_active ? mem_rdata : 8'h00;
            r_hsync <= (r_h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
            r_vsync <= (r_v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign o_pix         = r_pix;
    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = !rst && (r_h_cnt == '0) && (r_v_cnt == '0) && !r_phase;
    assign o_vblank      = !rst && ((r_v_cnt < V_START) || (r_v_cnt >= V_STOP));

endmodule

// File: tb/tb_vga_fb_scheduler.sv
`timescale 1ns/1ps
// Purpose : directed bench for vga_fb_scheduler on a reduced screen geometry.
// Latency : pixel expectations are queued when a pixel is fetched and popped one pixel later.
// Backpressure: writers are driven directly; grants are sampled mid-cycle.

module tb_vga_fb_scheduler;

    localparam int HS = 8, HB = 8, HA = 32, HT = 56;
    localparam int VS = 2, VB = 3, VA = 8, VT = 16;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;
    localparam int FRAME = 2 * HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  wr_req = 2'b00;
    logic [14:0] wr_addr0 = '0, wr_addr1 = '0;
    logic [7:0]  wr_data0 = '0, wr_data1 = '0;
    logic [1:0]  wr_gnt;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        o_hsync, o_vsync, o_de, o_frame_start, o_vblank;
    logic [7:0]  o_pix;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  ram [0:32767];
    int          ref_h = 0, ref_v = 0;
    logic        ref_ph = 1'b0;
    logic [10:0] sb_q[$];

    vga_fb_scheduler #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
        .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_pix(o_pix),
        .o_frame_start(o_frame_start), .o_vblank(o_vblank)
    );

    always #10 clk = ~clk;

    function automatic bit act(input int h, input int v);
        return (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
    endfunction

    function automatic int daddr(input int h, input int v);
        return ((v - VST) / 4) * 160 + (h - HST) / 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int h, input int v, input logic ph);
        for (int n = 0; n < 4 * FRAME; n++) begin
            if (ref_h == h && ref_v == v && ref_ph == ph) return;
            tick;
        end
    endtask

    // Framebuffer RAM: preloaded with the low address byte, synchronous read.
    initial begin
        for (int a = 0; a < 32768; a++) ram[a] = a[7:0];
    end

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    // Reference timing: where the beam should be in the current cycle.
    always @(posedge clk) begin
        if (rst) begin
            ref_ph <= 1'b0;
            ref_h  <= 0;
            ref_v  <= 0;
        end else begin
            ref_ph <= ~ref_ph;
            if (ref_ph) begin
                if (ref_h == HT - 1) begin
                    ref_h <= 0;
                    ref_v <= (ref_v == VT - 1) ? 0 : ref_v + 1;
                end else begin
                    ref_h <= ref_h + 1;
                end
            end
        end
    end

    // Continuous monitor: display-slot addressing, status outputs and pixel scoreboard.
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst) begin
            sb_q.delete();
        end else begin
            chk("frame_start", o_frame_start, (ref_h == 0 && ref_v == 0 && !ref_ph));
            chk("vblank", o_vblank, (ref_v < VST || ref_v >= VST + VA));
            if (!ref_ph && act(ref_h, ref_v)) begin
                chk("disp_addr", mem_addr, daddr(ref_h, ref_v));
                chk("disp_we", mem_we, 0);
                chk("disp_gnt", wr_gnt, 0);
            end
            if (!ref_ph) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("pix_out", {o_de, o_hsync, o_vsync, o_pix}, e);
                end
            end else begin
                e = {act(ref_h, ref_v), (ref_h < HS), (ref_v < VS),
                     act(ref_h, ref_v) ? 8'(daddr(ref_h, ref_v)) : 8'h00};
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        int cyc, vs_n, fs_n, hs_n;

        tick;
        tick;
        wr_req   = 2'b11;
        wr_addr0 = 15'd1000; wr_data0 = 8'h3C;
        wr_addr1 = 15'd2000; wr_data1 = 8'hC3;
        @(negedge clk);
        chk("rst_gnt", wr_gnt, 2'b00);
        chk("rst_we", mem_we, 0);
        chk("rst_hsync", o_hsync, 1);
        chk("rst_vsync", o_vsync, 1);
        chk("rst_de", o_de, 0);
        chk("rst_pix", o_pix, 0);
        chk("rst_fs", o_frame_start, 0);

        // First cycle after reset: frame origin, blanking, both writers requesting.
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("fs_after_rst", o_frame_start, 1);
        chk("vblank_origin", o_vblank, 1);
        exp_g = 2'b01;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                tick;
                @(negedge clk);
            end
            chk("arb_gnt", wr_gnt, exp_g);
            chk("arb_we", mem_we, 1);
            chk("arb_addr", mem_addr, (exp_g == 2'b01) ? 15'd1000 : 15'd2000);
            chk("arb_wdata", mem_wdata, (exp_g == 2'b01) ? 8'h3C : 8'hC3);
            exp_g = {exp_g[0], exp_g[1]};
        end
        tick;
        wr_req = 2'b00;

        // Frame period from the first pulse.
        cyc = 6;
        while (cyc < 2 * FRAME) begin
            @(negedge clk);
            if (o_frame_start) break;
            tick;
            cyc++;
        end
        chk("frame_period", cyc, FRAME);

        vs_n = 0;
        fs_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick;
            @(negedge clk);
            if (o_vsync) vs_n++;
            if (o_frame_start) fs_n++;
        end
        chk("vsync_clks", vs_n, 2 * VS * HT);
        chk("fs_per_frame", fs_n, 1);

        tick;
        wait_pos(0, 6, 1'b0);
        hs_n = 0;
        for (int i = 0; i < 2 * HT; i++) begin
            @(negedge clk);
            if (o_hsync) hs_n++;
            tick;
        end
        chk("hsync_clks", hs_n, 2 * HS);

        // Display-slot corners and display-enable lag.
        wait_pos(HST, VST, 1'b0);
        @(negedge clk);
        chk("addr_first", mem_addr, 0);
        chk("de_lag0", o_de, 0);
        tick;
        @(negedge clk);
        chk("de_lag1", o_de, 0);
        tick;
        @(negedge clk);
        chk("de_lag2", o_de, 1);
        tick;
        wait_pos(HST + HA - 1, VST, 1'b0);
        @(negedge clk);
        chk("addr_line_end", mem_addr, 7);
        tick;
        wait_pos(HST + HA - 1, VST + VA - 1, 1'b0);
        @(negedge clk);
        chk("addr_last", mem_addr, 167);

        // Active line: writer only served on phase=1.
        tick;
        wait_pos(20, 6, 1'b0);
        wr_req = 2'b01; wr_addr0 = 15'd300; wr_data0 = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("act_gnt", wr_gnt, ref_ph ? 2'b01 : 2'b00);
            chk("act_we", mem_we, ref_ph);
            tick;
        end
        wr_req = 2'b00;

        // Out-of-range address is granted but not written.
        wait_pos(0, 14, 1'b0);
        wr_req = 2'b01; wr_addr0 = 15'd19200; wr_data0 = 8'h55;
        @(negedge clk);
        chk("oor_gnt", wr_gnt, 2'b01);
        chk("oor_we", mem_we, 0);
        tick;
        wr_addr0 = 15'd5; wr_data0 = 8'hAB;
        @(negedge clk);
        chk("wr5_gnt", wr_gnt, 2'b01);
        chk("wr5_we", mem_we, 1);
        chk("wr5_addr", mem_addr, 15'd5);
        chk("wr5_data", mem_wdata, 8'hAB);
        tick;
        wr_req = 2'b00;

        // Mid-frame reset on a granted write slot.
        wait_pos(30, 8, 1'b1);
        wr_req = 2'b01; wr_addr0 = 15'd400; wr_data0 = 8'h77;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_gnt", wr_gnt, 2'b00);
        chk("mrst_we", mem_we, 0);
        chk("mrst_fs", o_frame_start, 0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_fs_after", o_frame_start, 1);
        chk("mrst_gnt_after", wr_gnt, 2'b01);
        tick;
        wr_req = 2'b00;

        cyc = 1;
        while (cyc < 2 * FRAME) begin
            @(negedge clk);
            if (o_frame_start) break;
            tick;
            cyc++;
        end
        chk("frame_period_rst", cyc, FRAME);

        tick;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
